// File: rtl/countdown_timer32_if.sv
// rtl/countdown_timer32_if.sv - control and status bundle for countdown_timer32
interface countdown_timer32_if;
    logic        load;
    logic [31:0] load_value;
    logic        start;
    logic        pause;
    logic        tick;
    logic [31:0] count;
    logic        running;
    logic        expired;
    logic        done;
    logic [1:0]  state;

    modport master (
        output load, load_value, start, pause, tick,
        input  count, running, expired, done, state
    );

    modport slave (
        input  load, load_value, start, pause, tick,
        output count, running, expired, done, state
    );
endinterface

// File: rtl/countdown_timer32.sv
// rtl/countdown_timer32.sv - 32-bit prescaled down-counter with expiry flag (optional COUNTDOWN_AUTORELOAD_EN)
module countdown_timer32 #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    countdown_timer32_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [15:0] DIV_M1 = 16'(TICK_DIV - 1);

    state_t      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic [15:0] presc_q, presc_d;
    logic        done_q, done_d;
    logic        running_q, expired_q;

`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [31:0] shadow_q;

    // Remember the last loaded duration so a finished run can restart itself
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
        end else if (bus.load) begin
            shadow_q <= bus.load_value;
        end
    end
`endif

    // Next-state logic; load overrides everything, pause overrides start
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (bus.load) begin
            count_d = bus.load_value;
            presc_d = '0;
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.pause) begin
                        if (count_q == 32'd0) begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.pause) begin
                        state_d = ST_PAUSE;
                    end else if (bus.tick) begin
                        if (presc_q == DIV_M1) begin
                            presc_d = '0;
                            if (count_q == 32'd1) begin
                                done_d = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                                count_d = shadow_q;
`else
                                count_d = '0;
                                state_d = ST_EXPIRED;
`endif
                            end else if (count_q != 32'd0) begin
                                count_d = count_q - 32'd1;
                            end
                        end else begin
                            presc_d = presc_q + 16'd1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (bus.start && !bus.pause) begin
                        state_d = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    count_d = '0;
                end
            endcase
        end
    end

    // State and registered status outputs; status flags derive from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            presc_q   <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            done_q    <= done_d;
            running_q <= (state_d == ST_RUN);
            expired_q <= (state_d == ST_EXPIRED);
        end
    end

    assign bus.count   = count_q;
    assign bus.state   = state_q;
    assign bus.running = running_q;
    assign bus.expired = expired_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_countdown_timer32.sv
// tb/tb_countdown_timer32.sv - scoreboard bench for countdown_timer32 with random stimulus
module tb_countdown_timer32;
    localparam int DIV = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;

    typedef struct packed {
        logic [31:0] count;
        logic [1:0]  state;
        logic        running;
        logic        expired;
        logic        done;
    } obs_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    countdown_timer32_if bus();
    countdown_timer32 #(.TICK_DIV(DIV)) dut (.clk(clk), .reset(reset), .bus(bus));

    obs_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   stim_done = 1'b0;

    // Reference model: remaining count, mode, ticks gathered toward the next decrement
    logic [31:0] m_cnt = '0;
    int          m_mode = M_IDLE;
    int          m_ticks = 0;
    logic        m_done = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
    logic [31:0] m_reload = '0;
`endif

    function automatic obs_t model_obs();
        obs_t o;
        o.count   = m_cnt;
        o.state   = 2'(m_mode);
        o.running = (m_mode == M_RUN);
        o.expired = (m_mode == M_EXP);
        o.done    = m_done;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.count   = bus.count;
        o.state   = bus.state;
        o.running = bus.running;
        o.expired = bus.expired;
        o.done    = bus.done;
        return o;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s t=%0t: got count=%0d state=%0d run=%b exp=%b done=%b, want count=%0d state=%0d run=%b exp=%b done=%b",
                     name, $time, act.count, act.state, act.running, act.expired, act.done,
                     req.count, req.state, req.running, req.expired, req.done);
        end
    endtask

    task automatic model_step(input logic r, input logic ld, input logic [31:0] lv,
                              input logic st, input logic pa, input logic tk);
        if (r) begin
            m_cnt = '0; m_mode = M_IDLE; m_ticks = 0; m_done = 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
            m_reload = '0;
`endif
            return;
        end
        m_done = 1'b0;
        if (ld) begin
            m_cnt = lv; m_ticks = 0; m_mode = M_IDLE;
`ifdef COUNTDOWN_AUTORELOAD_EN
            m_reload = lv;
`endif
        end else if (m_mode == M_IDLE) begin
            if (st && !pa) begin
                if (m_cnt == 0) begin m_mode = M_EXP; m_done = 1'b1; end
                else m_mode = M_RUN;
            end
        end else if (m_mode == M_RUN) begin
            if (pa) m_mode = M_PAUSE;
            else if (tk) begin
                m_ticks = m_ticks + 1;
                if (m_ticks == DIV) begin
                    m_ticks = 0;
                    m_cnt = m_cnt - 1;
                    if (m_cnt == 0) begin
                        m_done = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                        m_cnt = m_reload;
`else
                        m_mode = M_EXP;
`endif
                    end
                end
            end
        end else if (m_mode == M_PAUSE) begin
            if (st && !pa) m_mode = M_RUN;
        end
    endtask

    // One cycle of stimulus: drive at negedge, predict, queue the expected post-edge view
    task automatic apply(input logic r, input logic ld, input logic [31:0] lv,
                         input logic st, input logic pa, input logic tk);
        obs_t zero;
        @(negedge clk);
        reset = r; bus.load = ld; bus.load_value = lv;
        bus.start = st; bus.pause = pa; bus.tick = tk;
        model_step(r, ld, lv, st, pa, tk);
        exp_q.push_back(model_obs());
        if (r) begin
            zero = '0;
            #1;
            check("async_reset", dut_obs(), zero);
        end
    endtask

    // Monitor: every clock edge presents a new output word; compare with the oldest prediction
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("cycle", dut_obs(), e);
            end
        end
    end

    initial begin
        #2_000_000;
        miscompares++;
        $display("FAIL watchdog: stimulus still running at t=%0t, want finished", $time);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        obs_t drained, want_empty;
        bus.load = 0; bus.load_value = '0; bus.start = 0; bus.pause = 0; bus.tick = 0;
        apply(1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        // one-shot run of 3 decrements
        apply(0, 1, 3, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3 * DIV; i++) begin
            apply(0, 0, 0, 0, 0, 1);
            apply(0, 0, 0, 0, 0, 0);
        end
        apply(0, 0, 0, 1, 1, 1);
        // load collides with the final decrement
        apply(0, 1, 1, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < DIV - 1; i++) apply(0, 0, 0, 0, 0, 1);
        apply(0, 1, 7, 1, 0, 1);
        // pause collides with the final decrement, then resume
        apply(0, 1, 1, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < DIV - 1; i++) apply(0, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 0, 1);
        // start with zero count
        apply(0, 1, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 0, 0);
        // reset in the middle of a run
        apply(0, 1, 9, 0, 0, 0);
        apply(0, 0, 0, 1, 0, 0);
        apply(0, 0, 0, 0, 0, 1);
        apply(1, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 0, 1);
        apply(0, 0, 0, 1, 0, 1);
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            logic        r, ld, st, pa, tk;
            logic [31:0] lv;
            r  = ($urandom_range(0, 399) == 0);
            ld = ($urandom_range(0, 19) == 0);
            lv = ($urandom_range(0, 31) == 0) ? 32'($urandom) : 32'($urandom_range(0, 6));
            st = ($urandom_range(0, 3) == 0);
            pa = ($urandom_range(0, 11) == 0);
            tk = ($urandom_range(0, 1) == 0);
            apply(r, ld, lv, st, pa, tk);
        end
        apply(0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        drained = '0; want_empty = '0;
        drained.count = 32'(exp_q.size());
        check("scoreboard_drain", drained, want_empty);
        stim_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/countdown_timer32.md
# countdown_timer32

Synchronous 32-bit down-counter that runs opposite to the event up-counter. Software or the game FSM loads a duration, starts it, and the block decrements once per prescaled tick until it reaches zero, then flags expiry. It drives the round timer and mole-visible windows in the Whack-A-Mole datapath.

## Interface
- `TICK_DIV`, default 1: number of `tick` strobes per decrement, legal range 1..65535.
- `clk` input, 1 bit: system clock; all state changes on its rising edge.
- `reset` input, 1 bit: reset, asynchronous, active-high.
- `load` input, 1 bit: load `load_value` into `count`.
- `load_value` input, 32 bits: duration in decrements.
- `start` input, 1 bit: begin or resume counting.
- `pause` input, 1 bit: hold counting.
- `tick` input, 1 bit: single-cycle time-base strobe.
- `count` output, 32 bits: remaining decrements.
- `running` output, 1 bit: high in RUN.
- `expired` output, 1 bit: level; high in EXPIRED.
- `done` output, 1 bit: one-cycle pulse on entry to EXPIRED.
- `state` output, 2 bits: IDLE=0, RUN=1, PAUSE=2, EXPIRED=3.

## Operation
- Reset values: `count`=0, `state`=IDLE, `running`=0, `expired`=0, `done`=0, prescaler=0.
- Priority per cycle, highest first: `reset` > `load` > `pause` > `start` > `tick`.
- `load` in any state:
  - `count`←`load_value`, prescaler←0, state←IDLE.
  - A `start` or `tick` in the same cycle is ignored.
- IDLE:
  - `start` with `count`≠0 → RUN.
  - `start` with `count`=0 → EXPIRED, with `done` pulse.
- RUN:
  - `pause` → PAUSE; prescaler holds.
  - On `tick`, prescaler increments.
  - When prescaler reaches TICK_DIV-1 on a `tick`: prescaler←0 and `count`←`count`-1.
  - If that decrement makes `count` 0 → EXPIRED.
- PAUSE:
  - `start` (without `pause`) → RUN.
  - `tick` is ignored.
- EXPIRED:
  - `count` holds 0; `start`, `pause` and `tick` are ignored.
  - Only `load` or `reset` leaves EXPIRED.
- Arithmetic:
  - `count` never wraps; no decrement is issued at 0.
  - The prescaler is 16 bits.
  - TICK_DIV=1 makes every `tick` a decrement.
- `start` while already in RUN, and `pause` while in PAUSE or IDLE, are no-ops.
- `reset` asserted mid-run forces reset values immediately, with no `done`.

## Timing
- All outputs are registered.
- `count`, `state`, `running` and `expired` update on the edge that samples the causing input.
- `done` is high for exactly the one cycle in which `state` first reads EXPIRED.
- Decrement latency: `count` changes on the clock edge that samples the qualifying `tick`.
- Total run duration from `start` is `load_value`×TICK_DIV ticks.
- `tick` held high for N cycles counts as N ticks.
- `load` and the final decrement in the same cycle: `load` wins, no `done`.
- `pause` and the final decrement in the same cycle: `pause` wins, `count` stays 1, state→PAUSE.
- `reset` deassertion is synchronised externally; the block is first sensitive to inputs on the edge after `reset` falls.

## Configuration
- Macro `COUNTDOWN_AUTORELOAD_EN`, with-macro behaviour:
  - A shadow register captures `load_value` on every `load`.
  - On the decrement that would reach 0, `count`←shadow, state stays RUN, and `done` pulses for one cycle.
  - `expired` never asserts, except after `start` with shadow=0 (then behaves as without the macro).
- Without the macro: one-shot behaviour as described above, and no shadow register is built.

## Test plan
- Basic one-shot: reset, load 3, start, one `tick` per 4 cycles with TICK_DIV=1 → `count` reads 3,2,1,0; `done` pulses once at 0; `expired`=1 and `state`=3 thereafter.
- Prescaler: TICK_DIV=4, load 2, start, 8 ticks → `count`=1 after tick 4 and `count`=0 plus `done` after tick 8; no change on ticks 1–3.
- Pause/resume: load 5, start, 2 ticks, pause, 10 ticks, start, 3 ticks → `count` holds 3 while paused; EXPIRED after the final tick.
- Collisions:
  - load 1, start, then `tick`+`load`(value 7) in the same cycle → `count`=7, IDLE, no `done`.
  - `pause` + final `tick` → `count`=1, PAUSE.
- Zero and reset:
  - `start` with `count`=0 → EXPIRED with `done` on the next edge.
  - `reset` pulsed mid-run with `count`=9 → all outputs 0 asynchronously; later ticks ignored.
- With `COUNTDOWN_AUTORELOAD_EN`: load 2, start, 6 ticks → `count` reads 2,1,2,1,2,1,2; `done` pulses on ticks 2, 4 and 6; `expired` stays 0.
